add32_seq_ctrl: RTL and testbench

Multi-cycle sequencer that performs a 32-bit add (and optionally subtract) by time-multiplexing one 8-bit carry-select adder slice (`csa8`) over four cycles, chaining the carry between slices in a register. It sits beside the pipelined CPU datapath as an area-reduced arithmetic unit: requests arrive on a valid/ready handshake and results leave on a second valid/ready handshake. Flags (carry, signed overflow, zero) are produced with the result.

---
 rtl/add32_seq_ctrl.sv | 132 +++++++++++++
 tb/tb_add32_seq_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/add32_seq_ctrl.sv
// 32-bit add/subtract sequencer reusing one 8-bit carry-select slice over four cycles.
// Optional subtract support is built when the macro ADD_SEQ_SUB_EN is defined.
module add32_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        op_sub,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] sum,
  output logic        carry_out,
  output logic        overflow,
  output logic        zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nx;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic        carry_r;
  logic [1:0]  cnt_r;
  logic        accept_s;
  logic        sub_s;
  logic [31:0] b_in_s;
  logic [7:0]  slice_sum_s;
  logic        slice_c_s;
  logic        slice_v_s;

  // Carry-select slice: low nibble ripples, high nibble precomputed for both carries.
  // Returns {overflow, carry, sum[7:0]}.
  function automatic logic [9:0] csa8(input logic [7:0] a, input logic [7:0] b,
                                      input logic cin);
    logic [4:0] lo;
    logic [4:0] hi0;
    logic [4:0] hi1;
    logic [4:0] hi;
    logic       v;
    lo  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0000, cin};
    hi0 = {1'b0, a[7:4]} + {1'b0, b[7:4]};
    hi1 = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;
    hi  = lo[4] ? hi1 : hi0;
    v   = (a[7] == b[7]) && (hi[3] != a[7]);
    return {v, hi[4], hi[3:0], lo[3:0]};
  endfunction

`ifdef ADD_SEQ_SUB_EN
  assign sub_s  = op_sub;
  assign b_in_s = op_b ^ {32{op_sub}};
`else
  logic unused_op_sub;
  assign unused_op_sub = op_sub;
  assign sub_s  = 1'b0;
  assign b_in_s = op_b;
`endif

  assign accept_s = (state_r == IDLE) && req_valid;
  assign {slice_v_s, slice_c_s, slice_sum_s} =
    csa8(a_r[{cnt_r, 3'b000} +: 8], b_r[{cnt_r, 3'b000} +: 8], carry_r);

  // Next-state logic.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) state_nx = RUN;
        else           state_nx = IDLE;
      end
      RUN: begin
        if (cnt_r == 2'd3) state_nx = DONE;
        else               state_nx = RUN;
      end
      DONE: begin
        if (resp_ready) state_nx = IDLE;
        else            state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register with handshake outputs registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
    end else begin
      state_r    <= state_nx;
      req_ready  <= (state_nx == IDLE);
      resp_valid <= (state_nx == DONE);
    end
  end

  // Operand latch, slice sequencing and result/flag capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r       <= 32'd0;
      b_r       <= 32'd0;
      carry_r   <= 1'b0;
      cnt_r     <= 2'd0;
      sum       <= 32'd0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else if (accept_s) begin
      a_r     <= op_a;
      b_r     <= b_in_s;
      carry_r <= sub_s;
      cnt_r   <= 2'd0;
      sum     <= 32'd0;
    end else if (state_r == RUN) begin
      sum[{cnt_r, 3'b000} +: 8] <= slice_sum_s;
      carry_r <= slice_c_s;
      cnt_r   <= cnt_r + 2'd1;
      // Bytes 0-2 already hold this operation's slices when the top slice lands.
      if (cnt_r == 2'd3) begin
        carry_out <= slice_c_s;
        overflow  <= slice_v_s;
        zero      <= (sum[23:0] == 24'd0) && (slice_sum_s == 8'd0);
      end
    end
  end

endmodule

// File: tb/tb_add32_seq_ctrl.sv
// Self-checking bench for add32_seq_ctrl: vector table, scoreboard queue, and
// hand-written backpressure and mid-operation reset sequences.
module tb_add32_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_sub;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] sum;
  logic        carry_out;
  logic        overflow;
  logic        zero;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] s;
    logic        c;
    logic        v;
    logic        z;
  } vec_t;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  vec_t vecs[7];
  exp_t sb[$];

  add32_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .op_a(op_a), .op_b(op_b), .op_sub(op_sub),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .sum(sum), .carry_out(carry_out), .overflow(overflow), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Present a request, wait (bounded) for acceptance, push its expected result.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub,
                      input logic [31:0] s, input logic c, input logic v, input logic z);
    int n;
    exp_t e;
    req_valid = 1'b1;
    op_a = a;
    op_b = b;
    op_sub = sub;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk);
    e.s = s; e.c = c; e.v = v; e.z = z;
    sb.push_back(e);
    #1;
    req_valid = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
    op_sub = 1'($urandom_range(1, 0));
    chk("req_ready_in_run", {31'd0, req_ready}, 32'd0);
  endtask

  // Wait (bounded) for the response, compare against the scoreboard, optionally handshake.
  task automatic collect(input bit do_hs, input string tag);
    int lat;
    exp_t e;
    lat = 0;
    while (!resp_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, 32'd4);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_scoreboard: got response, expected none queued", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_sum"}, sum, e.s);
      chk({tag, "_carry"}, {31'd0, carry_out}, {31'd0, e.c});
      chk({tag, "_overflow"}, {31'd0, overflow}, {31'd0, e.v});
      chk({tag, "_zero"}, {31'd0, zero}, {31'd0, e.z});
    end
    if (do_hs) begin
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      chk({tag, "_hs_resp_valid"}, {31'd0, resp_valid}, 32'd0);
      chk({tag, "_hs_req_ready"}, {31'd0, req_ready}, 32'd1);
    end
  endtask

  initial begin
    vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0, 1'b0, 1'b0};
`ifdef ADD_SEQ_SUB_EN
    vecs[4] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
`else
    vecs[4] = '{32'h00000005, 32'h00000007, 1'b1, 32'h0000000C, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'h80000000, 32'h00000001, 1'b1, 32'h80000001, 1'b0, 1'b0, 1'b0};
`endif
    vecs[6] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};

    rst = 1'b1;
    req_valid = 1'b0;
    resp_ready = 1'b0;
    op_a = 32'd0;
    op_b = 32'd0;
    op_sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset_sum", sum, 32'd0);
    chk("reset_flags", {29'd0, carry_out, overflow, zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].s, vecs[i].c, vecs[i].v, vecs[i].z);
      collect(1'b1, $sformatf("vec%0d", i));
    end

    // Backpressure: response held while a new request waits.
    send(32'h00000FF0, 32'h00000010, 1'b0, 32'h00001000, 1'b0, 1'b0, 1'b0);
    collect(1'b0, "bp");
    req_valid = 1'b1;
    op_a = 32'h00000001;
    op_b = 32'h00000002;
    op_sub = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("bp_hold_sum", sum, 32'h00001000);
      chk("bp_hold_flags", {29'd0, carry_out, overflow, zero}, 32'd0);
      chk("bp_hold_resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp_hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("bp_idle_req_ready", {31'd0, req_ready}, 32'd1);
    chk("bp_idle_resp_valid", {31'd0, resp_valid}, 32'd0);
    begin
      exp_t e;
      e.s = 32'h00000003; e.c = 1'b0; e.v = 1'b0; e.z = 1'b0;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp2_accepted", {31'd0, req_ready}, 32'd0);
    collect(1'b1, "bp2");

    // Flags set, then reset after two slices of a new operation.
    send(vecs[6].a, vecs[6].b, vecs[6].sub, vecs[6].s, vecs[6].c, vecs[6].v, vecs[6].z);
    collect(1'b1, "pre_rst");
    send(32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk("midrst_sum", sum, 32'd0);
    chk("midrst_flags", {29'd0, carry_out, overflow, zero}, 32'd0);
    chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 6; k++) begin
        @(posedge clk); #1;
        if (resp_valid) seen++;
      end
      chk("postrst_no_resp", seen, 32'd0);
    end
    chk("postrst_req_ready", {31'd0, req_ready}, 32'd1);
    send(vecs[3].a, vecs[3].b, vecs[3].sub, vecs[3].s, vecs[3].c, vecs[3].v, vecs[3].z);
    collect(1'b1, "postrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
